// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and helpers for the convolution MAC datapath.
//   clog2       - ceiling log2, usable in parameter expressions
//   acc_width   - accumulator width that cannot overflow over a full run
//   level_cnt   - node count of a given pairwise-reduction tree level
//   sat_max/min - two's complement output bounds for a given width
//   tap_lsb     - bit offset of tap i in a packed window bus; the window
//                 generator uses the same function so both sides agree
package conv_pkg;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int dw, input int n, input int max_ch);
        return 2 * dw + clog2(n * max_ch);
    endfunction

    // Each level halves the previous one, rounding up for the odd leftover.
    function automatic int level_cnt(input int n, input int lvl);
        int c;
        c = n;
        for (int j = 0; j < lvl; j++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

    function automatic int tap_lsb(input int i, input int dw);
        return i * dw;
    endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: registered pairwise reduction of N operands.
// One register level per tree stage; latency T = clog2(N) cycles.
// An odd leftover operand at any level is registered through unchanged.
// A valid bit and an opaque tag travel alongside the data.
//   i_clk, i_reset  - clock, synchronous active-high reset (clears valids)
//   i_valid, i_tag  - sideband entering with i_data
//   i_data          - N packed operands, operand k at [k*WIDTH +: WIDTH]
//   o_valid, o_tag  - sideband delayed by T cycles
//   o_sum           - wrap-around sum of all operands (no saturation)
module pipelined_adder_tree
    import conv_pkg::*;
#(
    parameter int N     = 25,
    parameter int WIDTH = 43,
    parameter int TAG_W = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic [N*WIDTH-1:0] i_data,
    output logic               o_valid,
    output logic [TAG_W-1:0]   o_tag,
    output logic [WIDTH-1:0]   o_sum
);
    localparam int T = clog2(N);

    // Level 0 nodes are the unpacked inputs; deeper levels are flop outputs.
    genvar l, k;
    for (l = 0; l <= T; l++) begin : g_lvl
        localparam int CNT = level_cnt(N, l);
        logic [WIDTH-1:0] w_node [CNT];

        if (l == 0) begin : g_in
            for (k = 0; k < CNT; k++) begin : g_tap
                assign w_node[k] = i_data[k*WIDTH +: WIDTH];
            end
        end else begin : g_stage
            localparam int PCNT = level_cnt(N, l - 1);
            for (k = 0; k < CNT; k++) begin : g_node
                if (2 * k + 1 < PCNT) begin : g_add
                    always_ff @(posedge i_clk)
                        w_node[k] <= g_lvl[l-1].w_node[2*k] + g_lvl[l-1].w_node[2*k+1];
                end else begin : g_pass
                    always_ff @(posedge i_clk)
                        w_node[k] <= g_lvl[l-1].w_node[2*k];
                end
            end
        end
    end

    assign o_sum = g_lvl[T].w_node[0];

    if (T == 0) begin : g_comb
        assign o_valid = i_valid;
        assign o_tag   = i_tag;
    end else begin : g_pipe
        logic [T-1:0]     r_vld_pipe;
        logic [TAG_W-1:0] r_tag [T];

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= i_valid;
                for (int j = 1; j < T; j++) r_vld_pipe[j] <= r_vld_pipe[j-1];
            end
            r_tag[0] <= i_tag;
            for (int j = 1; j < T; j++) r_tag[j] <= r_tag[j-1];
        end

        assign o_valid = r_vld_pipe[T-1];
        assign o_tag   = r_tag[T-1];
    end

endmodule

// File: rtl/conv_mac_pipeline.sv
// conv_mac_pipeline: one KERNEL_SIZE x KERNEL_SIZE window per clock.
// Fixed-point tap multiply -> registered adder tree -> channel accumulator
// -> bias, optional ReLU, saturation. Latency T+3 where T = clog2(N).
//   i_clk, i_reset       - clock, synchronous active-high reset
//   i_in_valid           - beat present
//   i_in_first/i_in_last - open / close an accumulation (qualified by valid)
//   i_pixel_data         - N packed pixels, tap i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_weights            - N packed weights, same packing
//   i_bias, i_relu_en    - used only with the closing beat
//   o_out_valid          - one-cycle result strobe
//   o_add_result         - saturated, activated result (held between strobes)
//   o_out_sat            - clamping changed the result (held between strobes)
module conv_mac_pipeline
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int KERNEL_SIZE  = 5,
    parameter int FRAC_BIT     = 8,
    parameter int MAX_CHANNELS = 64
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic                                        i_in_valid,
    input  logic                                        i_in_first,
    input  logic                                        i_in_last,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] i_pixel_data,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] i_weights,
    input  logic [DATA_WIDTH-1:0]                       i_bias,
    input  logic                                        i_relu_en,
    output logic                                        o_out_valid,
    output logic [DATA_WIDTH-1:0]                       o_add_result,
    output logic                                        o_out_sat
);
    localparam int N         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, N, MAX_CHANNELS);
    // Tag layout: {first, last, relu_en, bias}
    localparam int TAG_W     = DATA_WIDTH + 3;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(DATA_WIDTH));

    // ---------------- product stage ----------------
    logic [N*ACC_WIDTH-1:0] w_prod;
    logic signed [PW-1:0]   w_a, w_b, w_mul, w_sh;

    always_comb begin
        w_prod = '0;
        w_a    = '0;
        w_b    = '0;
        w_mul  = '0;
        w_sh   = '0;
        for (int i = 0; i < N; i++) begin
            w_a   = {{DATA_WIDTH{i_pixel_data[tap_lsb(i, DATA_WIDTH) + DATA_WIDTH - 1]}},
                     i_pixel_data[tap_lsb(i, DATA_WIDTH) +: DATA_WIDTH]};
            w_b   = {{DATA_WIDTH{i_weights[tap_lsb(i, DATA_WIDTH) + DATA_WIDTH - 1]}},
                     i_weights[tap_lsb(i, DATA_WIDTH) +: DATA_WIDTH]};
            w_mul = w_a * w_b;
            // Arithmetic shift floors toward -inf, so tiny negatives become -1 LSB.
            w_sh  = w_mul >>> FRAC_BIT;
            w_prod[i*ACC_WIDTH +: ACC_WIDTH] = {{(ACC_WIDTH-PW){w_sh[PW-1]}}, w_sh};
        end
    end

    logic [N*ACC_WIDTH-1:0] r_prod;
    logic                   r_prod_vld;
    logic [TAG_W-1:0]       r_prod_tag;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_prod_vld <= 1'b0;
        else         r_prod_vld <= i_in_valid;
        r_prod     <= w_prod;
        r_prod_tag <= {i_in_first, i_in_last, i_relu_en, i_bias};
    end

    // ---------------- adder tree ----------------
    logic                 w_tree_vld;
    logic [TAG_W-1:0]     w_tree_tag;
    logic [ACC_WIDTH-1:0] w_tree_sum;

    pipelined_adder_tree #(
        .N     (N),
        .WIDTH (ACC_WIDTH),
        .TAG_W (TAG_W)
    ) u_tree (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (r_prod_vld),
        .i_tag   (r_prod_tag),
        .i_data  (r_prod),
        .o_valid (w_tree_vld),
        .o_tag   (w_tree_tag),
        .o_sum   (w_tree_sum)
    );

    logic                  w_t_first, w_t_last, w_t_relu;
    logic [DATA_WIDTH-1:0] w_t_bias;
    assign {w_t_first, w_t_last, w_t_relu, w_t_bias} = w_tree_tag;

    // ---------------- accumulator stage ----------------
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH-1:0]  w_acc_sum;
    logic                  r_fin_vld;
    logic [ACC_WIDTH-1:0]  r_fin_sum;
    logic [DATA_WIDTH-1:0] r_fin_bias;
    logic                  r_fin_relu;

    // A first beat ignores whatever is open, which also covers restarts.
    assign w_acc_sum = (w_t_first ? '0 : r_acc) + w_tree_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_fin_vld <= 1'b0;
        end else begin
            r_fin_vld <= w_tree_vld & w_t_last;
            // Closing beat clears acc so a following beat starts from zero.
            if (w_tree_vld) r_acc <= w_t_last ? '0 : w_acc_sum;
        end
        if (w_tree_vld && w_t_last) begin
            r_fin_sum  <= w_acc_sum;
            r_fin_bias <= w_t_bias;
            r_fin_relu <= w_t_relu;
        end
    end

    // ---------------- output stage ----------------
    logic signed [ACC_WIDTH-1:0] w_s, w_act;
    logic [DATA_WIDTH-1:0]       w_res;
    logic                        w_sat;

    always_comb begin
        w_s   = $signed(r_fin_sum) + $signed({{(ACC_WIDTH-DATA_WIDTH){r_fin_bias[DATA_WIDTH-1]}}, r_fin_bias});
        w_act = (r_fin_relu && w_s[ACC_WIDTH-1]) ? '0 : w_s;
        w_res = w_act[DATA_WIDTH-1:0];
        w_sat = 1'b0;
        if (w_act > SAT_MAX) begin
            w_res = SAT_MAX[DATA_WIDTH-1:0];
            w_sat = 1'b1;
        end else if (w_act < SAT_MIN) begin
            w_res = SAT_MIN[DATA_WIDTH-1:0];
            w_sat = 1'b1;
        end
    end

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_add_result;
    logic                  r_out_sat;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid  <= 1'b0;
            r_add_result <= '0;
            r_out_sat    <= 1'b0;
        end else begin
            r_out_valid <= r_fin_vld;
            if (r_fin_vld) begin
                r_add_result <= w_res;
                r_out_sat    <= w_sat;
            end
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_add_result = r_add_result;
    assign o_out_sat    = r_out_sat;

endmodule

// File: tb/tb_conv_mac_pipeline.sv
module tb_conv_mac_pipeline;
    localparam int DW  = 16;
    localparam int KS  = 5;
    localparam int N   = KS * KS;
    localparam int LAT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_first, in_last, relu_en;
    logic [N*DW-1:0] pix, wt;
    logic [DW-1:0]   bias;
    logic            out_valid, out_sat;
    logic [DW-1:0]   add_result;

    always #5 clk = ~clk;

    conv_mac_pipeline #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(KS), .FRAC_BIT(8), .MAX_CHANNELS(64)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_in_valid   (in_valid),
        .i_in_first   (in_first),
        .i_in_last    (in_last),
        .i_pixel_data (pix),
        .i_weights    (wt),
        .i_bias       (bias),
        .i_relu_en    (relu_en),
        .o_out_valid  (out_valid),
        .o_add_result (add_result),
        .o_out_sat    (out_sat)
    );

    int cyc = 0;
    int ntests = 0;
    int nfail = 0;
    int drive_cyc;
    int first_cyc;

    logic [DW-1:0] q_res[$];
    logic          q_sat[$];
    int            q_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_res.push_back(add_result);
            q_sat.push_back(out_sat);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] res_at(input int k);
        return (k < q_res.size()) ? 32'(q_res[k]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] sat_at(input int k);
        return (k < q_sat.size()) ? 32'(q_sat[k]) : 32'hDEAD_BEEF;
    endfunction
    function automatic int cyc_at(input int k);
        return (k < q_cyc.size()) ? q_cyc[k] : -1;
    endfunction

    task automatic beat(input logic f, input logic l, input logic [DW-1:0] p,
                        input logic [DW-1:0] w, input logic [DW-1:0] b, input logic r);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        for (int i = 0; i < N; i++) begin
            pix[i*DW +: DW] = p;
            wt[i*DW +: DW]  = w;
        end
        bias      = b;
        relu_en   = r;
        drive_cyc = cyc;
    endtask

    // Idle cycle with junk control to prove in_valid qualifies everything.
    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b1;
        in_last  = 1'b1;
        bias     = 16'h5555;
    endtask

    task automatic flush_and_clear(input int n);
        for (int i = 0; i < n; i++) bubble();
    endtask

    task automatic clear_q();
        q_res.delete();
        q_sat.delete();
        q_cyc.delete();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        relu_en = 1'b0; bias = '0; pix = '0; wt = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_result", 32'(add_result), 32'h0);
        chk("reset_sat", 32'(out_sat), 32'h0);
        reset = 1'b0;

        // identity, single beat
        clear_q();
        beat(1, 1, 16'h0100, 16'h0100, 16'h0000, 0);
        flush_and_clear(12);
        chk("ident_count", 32'(q_res.size()), 32'd1);
        chk("ident_result", res_at(0), 32'h1900);
        chk("ident_sat", sat_at(0), 32'h0);
        chk("ident_latency", 32'(cyc_at(0) - drive_cyc), 32'(LAT));
        chk("ident_hold", 32'(add_result), 32'h1900);

        // acc was cleared by the last beat: a last-only beat starts from zero
        clear_q();
        beat(0, 1, 16'h0100, 16'h0100, 16'h0000, 0);
        flush_and_clear(12);
        chk("nofirst_result", res_at(0), 32'h1900);

        // multi-channel, bias only on the closing beat
        clear_q();
        beat(1, 0, 16'h0100, 16'h0100, 16'h7777, 1);
        beat(0, 0, 16'h0100, 16'h0100, 16'h7777, 1);
        beat(0, 1, 16'h0100, 16'h0100, 16'h0100, 0);
        flush_and_clear(12);
        chk("multi_count", 32'(q_res.size()), 32'd1);
        chk("multi_result", res_at(0), 32'h4C00);
        chk("multi_latency", 32'(cyc_at(0) - drive_cyc), 32'(LAT));

        // sign, relu, truncation
        clear_q();
        beat(1, 1, 16'h0100, 16'hFF00, 16'h0000, 0);
        beat(1, 1, 16'h0100, 16'hFF00, 16'h0000, 1);
        beat(1, 1, 16'h0001, 16'h0001, 16'h0000, 0);
        flush_and_clear(12);
        chk("neg_result", res_at(0), 32'hE700);
        chk("neg_sat", sat_at(0), 32'h0);
        chk("relu_result", res_at(1), 32'h0000);
        chk("relu_sat", sat_at(1), 32'h0);
        chk("trunc_result", res_at(2), 32'h0000);

        // saturation both ways
        clear_q();
        beat(1, 1, 16'h7FFF, 16'h7FFF, 16'h0000, 0);
        beat(1, 1, 16'h8000, 16'h7FFF, 16'h0000, 0);
        flush_and_clear(12);
        chk("satpos_result", res_at(0), 32'h7FFF);
        chk("satpos_sat", sat_at(0), 32'h1);
        chk("satneg_result", res_at(1), 32'h8000);
        chk("satneg_sat", sat_at(1), 32'h1);

        // 20 back-to-back single-beat results
        clear_q();
        for (int k = 0; k < 20; k++) begin
            beat(1, 1, 16'h0100, 16'h0100, 16'(k), 0);
            if (k == 0) first_cyc = drive_cyc;
        end
        flush_and_clear(12);
        chk("stream_count", 32'(q_res.size()), 32'd20);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("stream_result_%0d", k), res_at(k), 32'h1900 + 32'(k));
            chk($sformatf("stream_cycle_%0d", k), 32'(cyc_at(k)), 32'(first_cyc + LAT + k));
        end

        // restart: second first-beat discards the open partial sum
        clear_q();
        beat(1, 0, 16'h0100, 16'h0100, 16'h0000, 0);
        beat(0, 0, 16'h0100, 16'h0100, 16'h0000, 0);
        beat(1, 0, 16'h0100, 16'h0080, 16'h0000, 0);
        beat(0, 1, 16'h0100, 16'h0100, 16'h0000, 0);
        flush_and_clear(12);
        chk("restart_count", 32'(q_res.size()), 32'd1);
        chk("restart_result", res_at(0), 32'h2580);

        // bubbles inside an accumulation
        clear_q();
        beat(1, 0, 16'h0100, 16'h0100, 16'h0000, 0);
        bubble();
        bubble();
        beat(0, 0, 16'h0100, 16'h0100, 16'h0000, 0);
        bubble();
        beat(0, 1, 16'h0100, 16'h0100, 16'h0000, 0);
        flush_and_clear(12);
        chk("bubble_count", 32'(q_res.size()), 32'd1);
        chk("bubble_result", res_at(0), 32'h4B00);

        // reset mid-accumulation drops in-flight beats and the partial sum
        clear_q();
        beat(1, 0, 16'h0100, 16'h0100, 16'h0000, 0);
        beat(0, 0, 16'h0100, 16'h0100, 16'h0000, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        chk("rst_mid_result_cleared", 32'(add_result), 32'h0);
        beat(1, 1, 16'h0100, 16'h0100, 16'h0000, 0);
        flush_and_clear(12);
        chk("rst_mid_count", 32'(q_res.size()), 32'd1);
        chk("rst_mid_result", res_at(0), 32'h1900);
        chk("rst_mid_latency", 32'(cyc_at(0) - drive_cyc), 32'(LAT));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
